fpga_input_conditioner: RTL and testbench
=========================================

// Module: fpga_input_conditioner
// PURPOSE
//  Board-input front end for the 16-bit CPU FPGA top: synchronizes raw KEY/SW pins,
//  debounces the push buttons, emits one-cycle press strobes, and runs an operand-entry
//  FSM. Each ENTER press latches the sign-extended switch value and offers it to the CPU
//  over a valid/ready handshake. Also supplies a debounced CPU reset level from KEY[0].
// PARAMETERS
//  NUM_KEYS        4       number of active-low push buttons
//  SW_WIDTH        10      switch count; SW[SW_WIDTH-1] is the sign bit
//  DATA_WIDTH      16      operand width; must be >= SW_WIDTH
//  SYNC_STAGES     2       synchronizer flops per input bit (>= 2)
//  DEBOUNCE_CYCLES 500000  cycles a key must hold its new level (10 ms @ 50 MHz)
//  ENTER_KEY       1       key index that captures an operand (must not be 0)
// PORTS
//  clk            in   1           system clock, all logic rising-edge
//  reset_n        in   1           asynchronous, active-low reset
//  key_n_raw      in   NUM_KEYS    raw buttons, 0 = pressed, asynchronous to clk
//  sw_raw         in   SW_WIDTH    raw slide switches, asynchronous to clk
//  key_down       out  NUM_KEYS    debounced level, 1 = held
//  key_press      out  NUM_KEYS    one-cycle strobe on debounced press edge
//  sw_sync        out  SW_WIDTH    synchronized switches (no debounce)
//  cpu_reset      out  1           equals key_down[0]
//  operand_data   out  DATA_WIDTH  sign-extended captured switch value
//  operand_valid  out  1           operand offered to CPU
//  operand_ready  in   1           CPU accepts operand when valid & ready
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk): sync flops and debounced state = released
//   (key sync chains = 1), counters = 0, all outputs 0, FSM = IDLE. Reset mid-handshake
//   drops the pending operand; operand_valid falls immediately.
//  Sync: every key/sw bit passes SYNC_STAGES flops; sw_sync is the last stage.
//  Debounce (per key): if synced level == stable level, counter clears; else counter
//   increments, and when it reaches DEBOUNCE_CYCLES-1 stable flips and counter clears.
//   Any bounce back to stable before that restarts the count. Pin-to-key_down latency =
//   SYNC_STAGES + DEBOUNCE_CYCLES cycles. Counter width = clog2(DEBOUNCE_CYCLES)+1.
//  key_press[i] = 1 for exactly one cycle when key_down[i] goes 0->1; release no strobe.
//   A key held through reset deassertion yields one key_press after the debounce time.
//  FSM states:
//   IDLE: on key_press[ENTER_KEY] -> operand_data <= {{(DATA_WIDTH-SW_WIDTH)
//         {sw_sync[SW_WIDTH-1]}}, sw_sync}; operand_valid <= 1; -> VALID (1-cycle latency).
//   VALID: operand_data/valid held stable; on operand_ready -> operand_valid <= 0;
//         -> WAIT_RELEASE. ENTER presses here are ignored (no queueing).
//   WAIT_RELEASE: -> IDLE when key_down[ENTER_KEY] == 0 (checked same cycle entered).
//  operand_data retains last value after the handshake until the next capture.
//  cpu_reset asserted does not reset this block; CPU owns its response.
//  Simultaneous ready + ENTER press in VALID: handshake completes, press discarded.
//  Switch changes after capture never alter operand_data.
// STRUCTURE
//  Shared package/include fpga_io_pkg: FSM state encoding (IDLE=0, VALID=1,
//   WAIT_RELEASE=2), sign-extend function, default DEBOUNCE_CYCLES constant.
//  Sub-module key_debouncer (sync chain + counter + stable + press strobe), one per key
//   via generate; top holds switch sync, operand FSM and output registers.
// TESTING (sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  Reset: reset_n=0 with keys pressed -> all outputs 0; release reset, keys held ->
//   key_down=4'b1111 after 6 cycles, one key_press per key, cpu_reset=1.
//  Bounce: key_n_raw[2] toggles 0/1 every 2 cycles for 20 cycles then held 0 ->
//   no key_press until 6 cycles after final edge, then exactly one strobe.
//  Capture: sw_raw=10'h3FB, press KEY[1] -> operand_data=16'hFFFB, valid next cycle
//   after key_press; ready held 0 for 10 cycles -> data/valid stable; ready=1 -> valid 0.
//  Positive: sw_raw=10'h07B -> operand_data=16'h007B.
//  No queueing: second ENTER press during VALID, or key held after handshake ->
//   no new operand until release then new press; sw change while VALID keeps data.
//  Reset mid-handshake: reset_n=0 while valid=1 -> valid=0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// Shared definitions for the board-input front end: operand FSM encoding,
// sign-extension helper and the default debounce interval.
package fpga_io_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      VALID        = 2'd1,
      WAIT_RELEASE = 2'd2
   } op_state_e;

   // val must be zero above bit width-1; the xor/subtract trick copies the sign bit upward.
   function automatic logic [31:0] sign_extend(input logic [31:0] val, input int width);
      logic [31:0] sign_bit;
      sign_bit = 32'd1 << (width - 1);
      return (val ^ sign_bit) - sign_bit;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push button: synchronizer chain, hold-time debouncer and press strobe.
// key_n_raw is active-low; key_down/key_press are active-high.
module key_debouncer
   import fpga_io_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n_raw,
   output logic key_down,
   output logic key_press
);

   localparam int                 CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]   CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   press_q, press_d;
   logic                   level;

   assign level = ~sync_q[SYNC_STAGES-1];

   // Counter runs only while the synced level disagrees with the stable level.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (level != stable_q) begin
         if (cnt_q == CNT_TC) begin
            stable_d = level;
            press_d  = level;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= '1;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], key_n_raw};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

   assign key_down  = stable_q;
   assign key_press = press_q;

endmodule

// File: rtl/fpga_input_conditioner.sv
// Board-input front end: per-key debouncers, switch synchronizer and the
// operand-entry FSM offering captured switch values over valid/ready.
//
//   state        | meaning
//   IDLE         | waiting for an ENTER press to capture the switches
//   VALID        | operand offered, held until the CPU asserts ready
//   WAIT_RELEASE | handshake done, waiting for ENTER to be released
module fpga_input_conditioner
   import fpga_io_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int SW_WIDTH        = 10,
   parameter int DATA_WIDTH      = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int ENTER_KEY       = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_KEYS-1:0]   key_n_raw,
   input  logic [SW_WIDTH-1:0]   sw_raw,
   output logic [NUM_KEYS-1:0]   key_down,
   output logic [NUM_KEYS-1:0]   key_press,
   output logic [SW_WIDTH-1:0]   sw_sync,
   output logic                  cpu_reset,
   output logic [DATA_WIDTH-1:0] operand_data,
   output logic                  operand_valid,
   input  logic                  operand_ready
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debouncer #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk       (clk),
         .reset_n   (reset_n),
         .key_n_raw (key_n_raw[g]),
         .key_down  (key_down[g]),
         .key_press (key_press[g])
      );
   end

   logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_pipe_q;
   logic [DATA_WIDTH-1:0]                sw_ext;

   op_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   assign sw_sync = sw_pipe_q[SYNC_STAGES-1];
   assign sw_ext  = DATA_WIDTH'(sign_extend(32'(sw_sync), SW_WIDTH));

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (key_press[ENTER_KEY]) begin
               data_d  = sw_ext;
               valid_d = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (operand_ready) begin
               valid_d = 1'b0;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!key_down[ENTER_KEY]) state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_pipe_q <= '0;
         state_q   <= IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         sw_pipe_q <= {sw_pipe_q[SYNC_STAGES-2:0], sw_raw};
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign cpu_reset     = key_down[0];
   assign operand_data  = data_q;
   assign operand_valid = valid_q;

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Directed plus randomized bench for fpga_input_conditioner against a
// cycle-level reference model built from pin histories and hold-time counts.
module tb_fpga_input_conditioner;

   localparam int NK  = 4;
   localparam int SWW = 10;
   localparam int DW  = 16;
   localparam int SS  = 2;
   localparam int DC  = 4;
   localparam int EK  = 1;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [NK-1:0]  key_n_raw = '1;
   logic [SWW-1:0] sw_raw = '0;
   logic           operand_ready = 1'b0;
   logic [NK-1:0]  key_down;
   logic [NK-1:0]  key_press;
   logic [SWW-1:0] sw_sync;
   logic           cpu_reset;
   logic [DW-1:0]  operand_data;
   logic           operand_valid;

   fpga_input_conditioner #(
      .NUM_KEYS        (NK),
      .SW_WIDTH        (SWW),
      .DATA_WIDTH      (DW),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .ENTER_KEY       (EK)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n_raw     (key_n_raw),
      .sw_raw        (sw_raw),
      .key_down      (key_down),
      .key_press     (key_press),
      .sw_sync       (sw_sync),
      .cpu_reset     (cpu_reset),
      .operand_data  (operand_data),
      .operand_valid (operand_valid),
      .operand_ready (operand_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [NK-1:0]  kpipe[$];
   logic [SWW-1:0] swpipe[$];
   logic [NK-1:0]  m_down, m_press;
   int             m_run[NK];
   logic           m_valid;
   logic [DW-1:0]  m_data;
   bit             m_wait;

   function automatic logic [DW-1:0] sext(input logic [SWW-1:0] v);
      int s;
      s = int'(v);
      if (s >= (1 << (SWW - 1))) s = s - (1 << SWW);
      return DW'(s);
   endfunction

   task automatic model_reset();
      kpipe.delete();
      swpipe.delete();
      for (int i = 0; i < SS; i++) begin
         kpipe.push_back('1);
         swpipe.push_back('0);
      end
      m_down  = '0;
      m_press = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_wait  = 1'b0;
   endtask

   task automatic model_edge();
      logic [NK-1:0]  old_down;
      logic [NK-1:0]  old_press;
      logic [SWW-1:0] old_sw;
      logic [NK-1:0]  lvl;
      logic [NK-1:0]  np;
      if (!reset_n) begin
         model_reset();
         return;
      end
      old_down  = m_down;
      old_press = m_press;
      old_sw    = swpipe[0];
      if (m_valid) begin
         if (operand_ready) begin
            m_valid = 1'b0;
            m_wait  = 1'b1;
         end
      end else if (m_wait) begin
         if (!old_down[EK]) m_wait = 1'b0;
      end else if (old_press[EK]) begin
         m_data  = sext(old_sw);
         m_valid = 1'b1;
      end
      lvl = ~kpipe[0];
      np  = '0;
      for (int k = 0; k < NK; k++) begin
         if (lvl[k] != m_down[k]) begin
            m_run[k]++;
            if (m_run[k] == DC) begin
               m_down[k] = lvl[k];
               np[k]     = lvl[k];
               m_run[k]  = 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_press = np;
      kpipe.push_back(key_n_raw);
      void'(kpipe.pop_front());
      swpipe.push_back(sw_raw);
      void'(swpipe.pop_front());
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("key_down",      32'(key_down),      32'(m_down));
      chk("key_press",     32'(key_press),     32'(m_press));
      chk("sw_sync",       32'(sw_sync),       32'(swpipe[0]));
      chk("cpu_reset",     32'(cpu_reset),     32'(m_down[0]));
      chk("operand_data",  32'(operand_data),  32'(m_data));
      chk("operand_valid", 32'(operand_valid), 32'(m_valid));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic wait_enter_press(input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         found = key_press[EK];
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      int presses[NK];
      int bounce_press;

      model_reset();

      // Reset with every key held
      reset_n       = 1'b0;
      key_n_raw     = '0;
      sw_raw        = 10'h155;
      operand_ready = 1'b0;
      repeat (3) tick();
      chk("rst_key_down", 32'(key_down), 32'd0);
      chk("rst_key_press", 32'(key_press), 32'd0);
      chk("rst_sw_sync", 32'(sw_sync), 32'd0);
      chk("rst_valid", 32'(operand_valid), 32'd0);
      chk("rst_data", 32'(operand_data), 32'd0);

      reset_n = 1'b1;
      for (int k = 0; k < NK; k++) presses[k] = 0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         for (int k = 0; k < NK; k++) presses[k] += int'(key_press[k]);
         if (c == 5) chk("held_down_c5", 32'(key_down), 32'h0);
         if (c == 6) chk("held_down_c6", 32'(key_down), 32'hF);
      end
      for (int k = 0; k < NK; k++) chk("held_press_count", 32'(presses[k]), 32'd1);
      chk("held_cpu_reset", 32'(cpu_reset), 32'd1);

      operand_ready = 1'b1;
      key_n_raw     = '1;
      repeat (2) tick();
      operand_ready = 1'b0;
      repeat (10) tick();

      // Bounce on KEY[2]
      bounce_press = 0;
      for (int c = 0; c < 20; c++) begin
         key_n_raw[2] = 1'((c / 2) % 2);
         tick();
         bounce_press += int'(key_press[2]);
      end
      key_n_raw[2] = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c < 6) bounce_press += int'(key_press[2]);
         else chk("bounce_strobe", 32'(key_press[2]), 32'd1);
      end
      chk("bounce_early", 32'(bounce_press), 32'd0);
      tick();
      chk("bounce_one_cycle", 32'(key_press[2]), 32'd0);
      key_n_raw[2] = 1'b1;
      repeat (8) tick();

      // Negative capture with a long ready stall, second press and switch change
      sw_raw = 10'h3FB;
      repeat (3) tick();
      key_n_raw[EK] = 1'b0;
      wait_enter_press("cap_press_seen");
      tick();
      chk("cap_valid", 32'(operand_valid), 32'd1);
      chk("cap_data", 32'(operand_data), 32'h0000FFFB);
      sw_raw        = 10'h0AA;
      key_n_raw[EK] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 8) key_n_raw[EK] = 1'b0;
         tick();
         chk("stall_valid", 32'(operand_valid), 32'd1);
         chk("stall_data", 32'(operand_data), 32'h0000FFFB);
      end
      operand_ready = 1'b1;
      tick();
      chk("hs_valid_low", 32'(operand_valid), 32'd0);
      operand_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("held_no_requeue", 32'(operand_valid), 32'd0);
      end
      chk("data_retained", 32'(operand_data), 32'h0000FFFB);
      key_n_raw[EK] = 1'b1;
      repeat (8) tick();

      // Positive capture
      sw_raw = 10'h07B;
      repeat (3) tick();
      key_n_raw[EK] = 1'b0;
      wait_enter_press("pos_press_seen");
      tick();
      chk("pos_valid", 32'(operand_valid), 32'd1);
      chk("pos_data", 32'(operand_data), 32'h0000007B);
      operand_ready = 1'b1;
      tick();
      operand_ready = 1'b0;
      key_n_raw[EK] = 1'b1;
      repeat (8) tick();

      // Reset in the middle of a handshake
      key_n_raw[EK] = 1'b0;
      wait_enter_press("mid_press_seen");
      tick();
      chk("mid_valid_before", 32'(operand_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(operand_valid), 32'd0);
      chk("mid_async_down", 32'(key_down), 32'd0);
      key_n_raw = '1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (8) tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            int k;
            k = int'($urandom_range(0, NK - 1));
            key_n_raw[k] = ~key_n_raw[k];
         end
         if ($urandom_range(0, 15) == 0) sw_raw = SWW'($urandom);
         operand_ready = ($urandom_range(0, 3) == 0);
         reset_n       = ($urandom_range(0, 999) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
